// File: rtl/avr_cmd_sequencer.sv
// avr_cmd_sequencer: queues (signal, level) requests and emits each as a
// 7-bit code on avr_ctrl, qualified by exactly one avr_clk transition.
module avr_cmd_sequencer #(
  parameter int DEPTH       = 4,
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_sel,
  input  logic       cmd_level,
  output logic       cmd_err,
  output logic       busy,
  output logic [6:0] avr_ctrl,
  output logic       avr_clk,
  output logic [6:0] shadow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 8;
  localparam logic [6:0] IDLE_CODE = 7'h01;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(RECOVER_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EDGE,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] fcnt_q;

  logic [2:0] cur_sel_q, cur_sel_d;
  logic cur_lvl_q, cur_lvl_d;
  logic [6:0] ctrl_q, ctrl_d;
  logic clk_q, clk_d;
  logic [6:0] shadow_q, shadow_d;
  logic err_q, err_d;

  logic push, pop, accept;

  function automatic logic [6:0] encode(
    input logic [2:0] s,
    input logic l
  );
    logic [6:0] c;
    case (s)
      3'd0: c = l ? 7'h03 : 7'h02;
      3'd1: c = l ? 7'h05 : 7'h04;
      3'd2: c = l ? 7'h07 : 7'h06;
      3'd3: c = l ? 7'h09 : 7'h08;
      3'd4: c = l ? 7'h0C : 7'h0A;
      3'd5: c = l ? 7'h0E : 7'h0D;
      3'd6: c = l ? 7'h10 : 7'h0F;
      default: c = IDLE_CODE;
    endcase
    return c;
  endfunction

  assign pop = (state_q == S_IDLE) && (fcnt_q != '0);
  assign cmd_ready = (fcnt_q != FULL) || pop;
  assign accept = cmd_valid && cmd_ready;
  assign push = accept && (cmd_sel != 3'd7);

  assign busy = (fcnt_q != '0) || (state_q != S_IDLE);
  assign avr_ctrl = ctrl_q;
  assign avr_clk = clk_q;
  assign shadow = shadow_q;
  assign cmd_err = err_q;

  // Request FIFO: storage and wrapping pointers, push/pop in one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {cmd_sel, cmd_level};
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10: fcnt_q <= fcnt_q + 1'b1;
        2'b01: fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // FSM state and phase counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end

  // Next state: walk each command through its setup/edge/hold/recover phases
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_SETUP;
          cnt_d = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_EDGE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EDGE: begin
        state_d = S_HOLD;
        cnt_d = '0;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_RECOVER;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RECOVER: begin
        if (cnt_q == REC_LAST) begin
          state_d = S_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Outputs: the code is loaded one cycle into SETUP so it is visible for
  // exactly SETUP_CYC cycles before avr_clk moves, and HOLD_CYC after
  always_comb begin
    cur_sel_d = cur_sel_q;
    cur_lvl_d = cur_lvl_q;
    ctrl_d = ctrl_q;
    clk_d = clk_q;
    shadow_d = shadow_q;
    err_d = accept && (cmd_sel == 3'd7);
    if (pop) {cur_sel_d, cur_lvl_d} = mem_q[rd_q];
    unique case (state_q)
      S_SETUP: begin
        if (cnt_q == '0) ctrl_d = encode(cur_sel_q, cur_lvl_q);
      end
      S_EDGE: begin
        clk_d = ~clk_q;
        if (cur_sel_q != 3'd7) shadow_d[cur_sel_q] = cur_lvl_q;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) ctrl_d = IDLE_CODE;
      end
      default: begin
      end
    endcase
  end

  // Output and current-command registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_sel_q <= '0;
      cur_lvl_q <= 1'b0;
      ctrl_q <= IDLE_CODE;
      clk_q <= 1'b0;
      shadow_q <= '0;
      err_q <= 1'b0;
    end else begin
      cur_sel_q <= cur_sel_d;
      cur_lvl_q <= cur_lvl_d;
      ctrl_q <= ctrl_d;
      clk_q <= clk_d;
      shadow_q <= shadow_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_avr_cmd_sequencer.sv
// tb_avr_cmd_sequencer: scoreboard bench for avr_cmd_sequencer.
// Expected codes are queued at push time and retired on each avr_clk edge.
module tb_avr_cmd_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_sel = '0;
  logic cmd_level = 1'b0;
  logic cmd_err;
  logic busy;
  logic [6:0] avr_ctrl;
  logic avr_clk;
  logic [6:0] shadow;

  typedef struct packed {
    logic [2:0] sel;
    logic lvl;
    logic [6:0] code;
  } exp_t;

  exp_t sbq[$];
  int edge_cyc[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [6:0] shadow_m = '0;
  logic prev_clk = 1'b0;
  logic [6:0] prev_ctrl = 7'h01;

  avr_cmd_sequencer dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel),
    .cmd_level(cmd_level),
    .cmd_err(cmd_err),
    .busy(busy),
    .avr_ctrl(avr_ctrl),
    .avr_clk(avr_clk),
    .shadow(shadow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] enc(input logic [2:0] s, input logic l);
    case (s)
      3'd0: return l ? 7'h03 : 7'h02;
      3'd1: return l ? 7'h05 : 7'h04;
      3'd2: return l ? 7'h07 : 7'h06;
      3'd3: return l ? 7'h09 : 7'h08;
      3'd4: return l ? 7'h0C : 7'h0A;
      3'd5: return l ? 7'h0E : 7'h0D;
      3'd6: return l ? 7'h10 : 7'h0F;
      default: return 7'h01;
    endcase
  endfunction

  // Bus monitor: retires one scoreboard entry per avr_clk transition
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_clk = avr_clk;
      prev_ctrl = avr_ctrl;
    end else begin
      checks++;
      if (avr_ctrl === 7'h0B) begin
        errors++;
        $display("FAIL code_0b: avr_ctrl=%h at cyc %0d", avr_ctrl, cyc);
      end
      if (avr_clk !== prev_clk) begin
        edge_cyc.push_back(cyc);
        checks++;
        if (avr_ctrl !== prev_ctrl) begin
          errors++;
          $display("FAIL ctrl_at_edge: ctrl %h -> %h with edge",
                   prev_ctrl, avr_ctrl);
        end
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL spurious_edge: edge with empty scoreboard cyc %0d",
                   cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checks++;
          if (avr_ctrl !== e.code) begin
            errors++;
            $display("FAIL edge_code: got %h expected %h", avr_ctrl, e.code);
          end
          shadow_m[e.sel] = e.lvl;
          checks++;
          if (shadow !== shadow_m) begin
            errors++;
            $display("FAIL shadow: got %b expected %b", shadow, shadow_m);
          end
        end
      end
      prev_clk = avr_clk;
      prev_ctrl = avr_ctrl;
    end
  end

  task automatic push(input logic [2:0] s, input logic l, output int stalls);
    bit got;
    stalls = 0;
    got = 0;
    cmd_valid = 1'b1;
    cmd_sel = s;
    cmd_level = l;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        break;
      end
      stalls++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready=%b expected 1", cmd_ready);
    end
    @(posedge clk);
    if (got && s != 3'd7) sbq.push_back({s, l, enc(s, l)});
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: busy=%b pending=%0d expected 0/0",
               busy, sbq.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({avr_ctrl, avr_clk, shadow} !== {7'h01, 1'b0, 7'h00}) begin
      errors++;
      $display("FAIL reset_bus: ctrl=%h clk=%b shadow=%h expected 01/0/00",
               avr_ctrl, avr_clk, shadow);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, cmd_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/err=%b%b%b expected 100",
               cmd_ready, busy, cmd_err);
    end
    shadow_m = '0;
  endtask

  task automatic test_single();
    logic [6:0] ctl [10];
    logic ck [10];
    logic c0;
    int n09, f, st;
    @(posedge clk);
    #1;
    c0 = avr_clk;
    push(3'd3, 1'b1, st);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ctl[i] = avr_ctrl;
      ck[i] = avr_clk;
    end
    n09 = 0;
    f = -1;
    for (int i = 0; i < 10; i++) begin
      if (ctl[i] == 7'h09) begin
        n09++;
        if (f < 0) f = i;
      end
    end
    checks++;
    if (n09 != 4) begin
      errors++;
      $display("FAIL single_len: code 09 for %0d cycles expected 4", n09);
    end
    checks++;
    if (f < 0 || f > 5) begin
      errors++;
      $display("FAIL single_start: first 09 index %0d expected 0..5", f);
    end else begin
      checks++;
      if ({ck[f], ck[f+1], ck[f+2], ck[f+3]} !== {c0, c0, ~c0, ~c0}) begin
        errors++;
        $display("FAIL single_edge: clk %b%b%b%b expected %b%b%b%b",
                 ck[f], ck[f+1], ck[f+2], ck[f+3], c0, c0, ~c0, ~c0);
      end
      checks++;
      if (ctl[f+4] !== 7'h01) begin
        errors++;
        $display("FAIL single_idle: ctrl=%h expected 01", ctl[f+4]);
      end
    end
    wait_idle();
    checks++;
    if (shadow[3] !== 1'b1) begin
      errors++;
      $display("FAIL single_shadow3: got %b expected 1", shadow[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ss [6] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd3};
    logic ll [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int st [6];
    @(posedge clk);
    #1;
    edge_cyc.delete();
    for (int i = 0; i < 6; i++) push(ss[i], ll[i], st[i]);
    checks++;
    if (st[0] + st[1] + st[2] + st[3] + st[4] != 0) begin
      errors++;
      $display("FAIL b2b_ready: stalls before full=%0d expected 0",
               st[0] + st[1] + st[2] + st[3] + st[4]);
    end
    checks++;
    if (st[5] != 3) begin
      errors++;
      $display("FAIL b2b_full_stall: stalls=%0d expected 3", st[5]);
    end
    wait_idle();
    checks++;
    if (edge_cyc.size() != 6) begin
      errors++;
      $display("FAIL b2b_edges: got %0d expected 6", edge_cyc.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (edge_cyc[i] - edge_cyc[i-1] != 7) begin
          errors++;
          $display("FAIL b2b_spacing: gap %0d expected 7",
                   edge_cyc[i] - edge_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_we();
    logic c0;
    int st;
    @(posedge clk);
    #1;
    c0 = avr_clk;
    push(3'd4, 1'b1, st);
    wait_idle();
    checks++;
    if (avr_clk !== ~c0) begin
      errors++;
      $display("FAIL we_clk: got %b expected %b", avr_clk, ~c0);
    end
    checks++;
    if (shadow[4] !== 1'b1) begin
      errors++;
      $display("FAIL we_shadow4: got %b expected 1", shadow[4]);
    end
  endtask

  task automatic test_illegal();
    logic c0;
    int st, nerr, bad;
    @(posedge clk);
    #1;
    c0 = avr_clk;
    push(3'd7, 1'b1, st);
    nerr = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_err) nerr++;
      if (avr_clk !== c0 || avr_ctrl !== 7'h01 || busy !== 1'b0) bad++;
    end
    checks++;
    if (nerr != 1) begin
      errors++;
      $display("FAIL illegal_err: pulses=%0d expected 1", nerr);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL illegal_quiet: bad cycles=%0d expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic c0;
    bit seen;
    int st, bad;
    @(posedge clk);
    #1;
    c0 = avr_clk;
    push(3'd1, 1'b0, st);
    push(3'd2, 1'b1, st);
    push(3'd0, 1'b0, st);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (avr_clk !== c0) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_edge: no edge seen, clk=%b", avr_clk);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({avr_ctrl, avr_clk, shadow, busy, cmd_ready, cmd_err}
        !== {7'h01, 1'b0, 7'h00, 3'b010}) begin
      errors++;
      $display("FAIL mid_reset: ctrl=%h clk=%b sh=%h b/r/e=%b%b%b",
               avr_ctrl, avr_clk, shadow, busy, cmd_ready, cmd_err);
    end
    sbq.delete();
    shadow_m = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avr_clk !== 1'b0 || avr_ctrl !== 7'h01 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_quiet: bad cycles=%0d expected 0", bad);
    end
    @(posedge clk);
    #1;
    push(3'd6, 1'b1, st);
    wait_idle();
    checks++;
    if (shadow !== 7'h40) begin
      errors++;
      $display("FAIL mid_after: shadow=%h expected 40", shadow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_we();
    test_illegal();
    test_reset_mid();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover: pending=%0d expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
